// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline sequencing controller placed beside the EX/MEM forwarding logic.
// It inserts bubbles for load-use hazards that forwarding cannot cover. It
// freezes the whole pipeline while a multi-cycle data-memory access is
// outstanding. It flushes IF/ID when decode resolves a taken branch.
//
// Optional build macro: HAZARD_STALL_COUNTERS_EN
//   defined   -> stall_cycles / flush_count are live 32-bit wrapping counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   idEx_mem_read       : instruction in EX is a load
//   idEx_write_reg      : destination register of the instruction in EX
//   decode_read_reg1/2  : source registers of the instruction in decode
//   branch_taken        : decode resolved a taken branch this cycle
//   dmem_req/dmem_ready : MEM-stage access request / completion
//   pc_write, ifId_write, ifId_flush, idEx_bubble, idEx_hold,
//   exMem_hold, memWb_bubble : pipeline register controls (combinational)
//   mem_error           : sticky memory-timeout flag
//   stall_cycles, flush_count : optional statistics counters
// -----------------------------------------------------------------------------
module hazard_controller #(
   parameter int unsigned LOAD_USE_BUBBLES = 1,
   parameter int unsigned MEM_TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        idEx_mem_read,
   input  logic [4:0]  idEx_write_reg,
   input  logic [4:0]  decode_read_reg1,
   input  logic [4:0]  decode_read_reg2,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        ifId_write,
   output logic        ifId_flush,
   output logic        idEx_bubble,
   output logic        idEx_hold,
   output logic        exMem_hold,
   output logic        memWb_bubble,
   output logic        mem_error,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   localparam logic [1:0] BUB_INIT  = 2'(LOAD_USE_BUBBLES - 1);
   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   logic [1:0] state_q,     state_d;
   logic [1:0] bub_cnt_q,   bub_cnt_d;
   logic [7:0] tmo_cnt_q,   tmo_cnt_d;
   logic       ret_lu_q,    ret_lu_d;
   logic       mem_error_q, mem_error_d;
   // High while in reset and for the first cycle after release.
   logic       init_q;

   logic lu_hazard_s;
   logic mem_stall_s;
   logic pc_write_s, ifId_write_s, ifId_flush_s, idEx_bubble_s;
   logic idEx_hold_s, exMem_hold_s, memWb_bubble_s;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign lu_hazard_s = idEx_mem_read && (idEx_write_reg != 5'd0) &&
                        ((idEx_write_reg == decode_read_reg1) ||
                         (idEx_write_reg == decode_read_reg2));
   assign mem_stall_s = dmem_req && !dmem_ready;

   // Next-state and output decode; memory wait outranks load-use outranks branch.
   always_comb begin
      state_d        = state_q;
      bub_cnt_d      = bub_cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      ret_lu_d       = ret_lu_q;
      mem_error_d    = mem_error_q;
      pc_write_s     = 1'b0;
      ifId_write_s   = 1'b0;
      ifId_flush_s   = 1'b0;
      idEx_bubble_s  = 1'b0;
      idEx_hold_s    = 1'b0;
      exMem_hold_s   = 1'b0;
      memWb_bubble_s = 1'b0;
      if (reset || init_q) begin
         // Pipeline is held empty: NOPs into IF/ID, ID/EX and MEM/WB.
         ifId_flush_s   = 1'b1;
         idEx_bubble_s  = 1'b1;
         memWb_bubble_s = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               pc_write_s   = 1'b1;
               ifId_write_s = 1'b1;
               if (mem_stall_s) begin
                  pc_write_s     = 1'b0;
                  ifId_write_s   = 1'b0;
                  idEx_hold_s    = 1'b1;
                  exMem_hold_s   = 1'b1;
                  memWb_bubble_s = 1'b1;
                  state_d        = ST_MEM_WAIT;
                  tmo_cnt_d      = 8'd1;
                  ret_lu_d       = 1'b0;
               end else if (lu_hazard_s) begin
                  // A taken branch seen here is ignored; decode re-evaluates it.
                  pc_write_s    = 1'b0;
                  ifId_write_s  = 1'b0;
                  idEx_bubble_s = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_d   = ST_LU_STALL;
                     bub_cnt_d = BUB_INIT;
                  end else begin
                     state_d   = ST_RUN;
                  end
               end else if (branch_taken) begin
                  ifId_flush_s = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_LU_STALL: begin
               if (mem_stall_s) begin
                  // Freeze overrides the bubble; bubble count is preserved.
                  idEx_hold_s    = 1'b1;
                  exMem_hold_s   = 1'b1;
                  memWb_bubble_s = 1'b1;
                  state_d        = ST_MEM_WAIT;
                  tmo_cnt_d      = 8'd1;
                  ret_lu_d       = 1'b1;
               end else begin
                  idEx_bubble_s = 1'b1;
                  bub_cnt_d     = bub_cnt_q - 2'd1;
                  if (bub_cnt_q <= 2'd1) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_LU_STALL;
                  end
               end
            end
            ST_MEM_WAIT: begin
               idEx_hold_s    = 1'b1;
               exMem_hold_s   = 1'b1;
               memWb_bubble_s = 1'b1;
               if (tmo_cnt_q != 8'hFF) begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q;
               end
               // A timeout abandons the access and resumes like a completion.
               if (dmem_ready || (tmo_cnt_q >= TMO_LIMIT)) begin
                  state_d = ret_lu_q ? ST_LU_STALL : ST_RUN;
                  if (!dmem_ready) begin
                     mem_error_d = 1'b1;
                  end else begin
                     mem_error_d = mem_error_q;
                  end
               end else begin
                  state_d = ST_MEM_WAIT;
               end
            end
            default: begin
               state_d        = ST_RUN;
               ifId_flush_s   = 1'b1;
               idEx_bubble_s  = 1'b1;
               memWb_bubble_s = 1'b1;
            end
         endcase
      end
   end

   // Controller state, counters and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         bub_cnt_q   <= 2'd0;
         tmo_cnt_q   <= 8'd0;
         ret_lu_q    <= 1'b0;
         mem_error_q <= 1'b0;
         init_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         bub_cnt_q   <= bub_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ret_lu_q    <= ret_lu_d;
         mem_error_q <= mem_error_d;
         init_q      <= 1'b0;
      end
   end

   assign pc_write     = pc_write_s;
   assign ifId_write   = ifId_write_s;
   assign ifId_flush   = ifId_flush_s;
   assign idEx_bubble  = idEx_bubble_s;
   assign idEx_hold    = idEx_hold_s;
   assign exMem_hold   = exMem_hold_s;
   assign memWb_bubble = memWb_bubble_s;
   assign mem_error    = mem_error_q;

`ifdef HAZARD_STALL_COUNTERS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Statistics: stalled-PC cycles and RUN-state flushes, wrapping at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (!init_q && !pc_write_s) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
         if (!init_q && (state_q == ST_RUN) && ifId_flush_s) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end else begin
            flush_cnt_q <= flush_cnt_q;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Two instances share the stimulus:
// u_a uses LOAD_USE_BUBBLES=1, MEM_TIMEOUT=4 and u_b uses
// LOAD_USE_BUBBLES=3, MEM_TIMEOUT=255. Each step checks only the instance it
// targets, and both are reset between sections.
module tb_hazard_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       idEx_mem_read;
   logic [4:0] idEx_write_reg;
   logic [4:0] rr1;
   logic [4:0] rr2;
   logic       branch_taken;
   logic       dmem_req;
   logic       dmem_ready;

   logic        pcw_a, ifw_a, iff_a, bub_a, idh_a, exh_a, mwb_a, err_a;
   logic [31:0] stall_a, flush_a;
   logic        pcw_b, ifw_b, iff_b, bub_b, idh_b, exh_b, mwb_b, err_b;
   logic [31:0] stall_b, flush_b;

   hazard_controller #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(4)) u_a (
      .clk(clk), .reset(reset), .idEx_mem_read(idEx_mem_read),
      .idEx_write_reg(idEx_write_reg), .decode_read_reg1(rr1),
      .decode_read_reg2(rr2), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pcw_a), .ifId_write(ifw_a), .ifId_flush(iff_a),
      .idEx_bubble(bub_a), .idEx_hold(idh_a), .exMem_hold(exh_a),
      .memWb_bubble(mwb_a), .mem_error(err_a),
      .stall_cycles(stall_a), .flush_count(flush_a));

   hazard_controller #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(255)) u_b (
      .clk(clk), .reset(reset), .idEx_mem_read(idEx_mem_read),
      .idEx_write_reg(idEx_write_reg), .decode_read_reg1(rr1),
      .decode_read_reg2(rr2), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pcw_b), .ifId_write(ifw_b), .ifId_flush(iff_b),
      .idEx_bubble(bub_b), .idEx_hold(idh_b), .exMem_hold(exh_b),
      .memWb_bubble(mwb_b), .mem_error(err_b),
      .stall_cycles(stall_b), .flush_count(flush_b));

   // Output vector order: pc_write, ifId_write, ifId_flush, idEx_bubble,
   // idEx_hold, exMem_hold, memWb_bubble.
   wire [6:0] vec_a = {pcw_a, ifw_a, iff_a, bub_a, idh_a, exh_a, mwb_a};
   wire [6:0] vec_b = {pcw_b, ifw_b, iff_b, bub_b, idh_b, exh_b, mwb_b};

   localparam logic [6:0] O_RST = 7'b0011001;
   localparam logic [6:0] O_RUN = 7'b1100000;
   localparam logic [6:0] O_BUB = 7'b0001000;
   localparam logic [6:0] O_FRZ = 7'b0000111;
   localparam logic [6:0] O_BR  = 7'b1110000;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      idEx_mem_read  = 1'b0;
      idEx_write_reg = 5'd0;
      rr1            = 5'd0;
      rr2            = 5'd0;
      branch_taken   = 1'b0;
      dmem_req       = 1'b0;
      dmem_ready     = 1'b0;
   endtask

   // Check instance A at the falling edge, then move to just after the next rising edge.
   task automatic exp_a(input string tag, input logic [6:0] e, input logic err);
      @(negedge clk);
      chk(tag, {25'd0, vec_a}, {25'd0, e});
      chk({tag, "_err"}, {31'd0, err_a}, {31'd0, err});
      @(posedge clk);
      #1;
   endtask

   task automatic exp_b(input string tag, input logic [6:0] e, input logic err);
      @(negedge clk);
      chk(tag, {25'd0, vec_b}, {25'd0, e});
      chk({tag, "_err"}, {31'd0, err_b}, {31'd0, err});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle();
      @(negedge clk);
      chk("rst_a", {25'd0, vec_a}, {25'd0, O_RST});
      chk("rst_b", {25'd0, vec_b}, {25'd0, O_RST});
      chk("rst_err_a", {31'd0, err_a}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_b("init_b", O_RST, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      do_reset();

      // Idle RUN outputs and load-use with LOAD_USE_BUBBLES=1.
      exp_a("run_idle", O_RUN, 1'b0);
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd5; rr2 = 5'd5;
      exp_a("lu_r2_bubble", O_BUB, 1'b0);
      idle();
      exp_a("lu_r2_after", O_RUN, 1'b0);

      // Register 0 never hazards.
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd0; rr1 = 5'd0;
      exp_a("r0_c1", O_RUN, 1'b0);
      exp_a("r0_c2", O_RUN, 1'b0);
      // Match on first source; no match; match without a load.
      idEx_write_reg = 5'd7; rr1 = 5'd7; rr2 = 5'd3;
      exp_a("lu_r1_bubble", O_BUB, 1'b0);
      rr1 = 5'd3; rr2 = 5'd4;
      exp_a("lu_nomatch", O_RUN, 1'b0);
      idEx_mem_read = 1'b0; rr1 = 5'd7;
      exp_a("lu_noload", O_RUN, 1'b0);
      // Back-to-back loads: two independent single bubbles.
      idle();
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd9; rr2 = 5'd9;
      exp_a("b2b_1", O_BUB, 1'b0);
      exp_a("b2b_2", O_BUB, 1'b0);
      idle();
      exp_a("b2b_end", O_RUN, 1'b0);

      // Memory wait: 3 not-ready cycles then ready -> 4 freeze cycles.
      // Hazard and branch are present too: the memory wait has priority.
      do_reset();
      dmem_req = 1'b1; idEx_mem_read = 1'b1; idEx_write_reg = 5'd5; rr2 = 5'd5;
      branch_taken = 1'b1;
      exp_a("mw_f1", O_FRZ, 1'b0);
      idle(); dmem_req = 1'b1;
      exp_a("mw_f2", O_FRZ, 1'b0);
      exp_a("mw_f3", O_FRZ, 1'b0);
      dmem_ready = 1'b1;
      exp_a("mw_f4", O_FRZ, 1'b0);
      idle();
      exp_a("mw_run", O_RUN, 1'b0);

      // Branch during a load-use stall is ignored, then taken next cycle.
      do_reset();
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd5; rr2 = 5'd5; branch_taken = 1'b1;
      exp_a("br_in_stall", O_BUB, 1'b0);
      idle(); branch_taken = 1'b1;
      exp_a("br_flush", O_BR, 1'b0);
      idle();
`ifdef HAZARD_STALL_COUNTERS_EN
      chk("flush_count", flush_a, 32'd1);
      chk("stall_cycles", stall_a, 32'd1);
`else
      chk("flush_tied", flush_a, 32'd0);
      chk("stall_tied", stall_a, 32'd0);
`endif
      exp_a("br_run", O_RUN, 1'b0);

      // Timeout with MEM_TIMEOUT=4: error after the 4th MEM_WAIT cycle.
      do_reset();
      dmem_req = 1'b1;
      exp_a("to_enter", O_FRZ, 1'b0);
      exp_a("to_w1", O_FRZ, 1'b0);
      exp_a("to_w2", O_FRZ, 1'b0);
      exp_a("to_w3", O_FRZ, 1'b0);
      exp_a("to_w4", O_FRZ, 1'b0);
      idle();
      exp_a("to_run", O_RUN, 1'b1);
      exp_a("to_sticky1", O_RUN, 1'b1);
      exp_a("to_sticky2", O_RUN, 1'b1);
      do_reset();
      exp_a("to_cleared", O_RUN, 1'b0);

      // LOAD_USE_BUBBLES=3: three bubbles, hazard re-presented is ignored.
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd5; rr2 = 5'd5;
      exp_b("lu3_b1", O_BUB, 1'b0);
      exp_b("lu3_b2", O_BUB, 1'b0);
      idle();
      exp_b("lu3_b3", O_BUB, 1'b0);
      exp_b("lu3_run", O_RUN, 1'b0);

      // Memory wait inside the second bubble.
      do_reset();
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd5; rr2 = 5'd5;
      exp_b("lum_b1", O_BUB, 1'b0);
      idle(); dmem_req = 1'b1;
      exp_b("lum_f1", O_FRZ, 1'b0);
      dmem_ready = 1'b1;
      exp_b("lum_f2", O_FRZ, 1'b0);
      idle();
      exp_b("lum_b2", O_BUB, 1'b0);
      exp_b("lum_b3", O_BUB, 1'b0);
      exp_b("lum_run", O_RUN, 1'b0);

      // Reset mid-stall: immediate reset outputs, stall not resumed.
      idEx_mem_read = 1'b1; idEx_write_reg = 5'd6; rr1 = 5'd6;
      exp_b("mid_b1", O_BUB, 1'b0);
      idle();
      #2;
      reset = 1'b1;
      #1;
      chk("mid_async", {25'd0, vec_b}, {25'd0, O_RST});
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_b("mid_init", O_RST, 1'b0);
      exp_b("mid_run", O_RUN, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller that sits beside the EX/MEM forwarding logic.
- Detects load-use hazards that forwarding cannot cover and inserts bubbles.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Flushes IF/ID on a taken branch resolved in decode. Drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- LOAD_USE_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (legal 1-3).
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_error is raised (legal 1-255).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- idEx_mem_read  input  1  instruction in EX is a load.
- idEx_write_reg  input  5  destination register of the instruction in EX.
- decode_read_reg1  input  5  first source register in decode.
- decode_read_reg2  input  5  second source register in decode.
- branch_taken  input  1  decode resolved a taken branch this cycle.
- dmem_req  input  1  MEM stage is issuing a data-memory access.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC update enable.
- ifId_write  output  1  IF/ID register load enable.
- ifId_flush  output  1  IF/ID register is cleared to a NOP.
- idEx_bubble  output  1  ID/EX register loads a NOP.
- idEx_hold  output  1  ID/EX register keeps its value.
- exMem_hold  output  1  EX/MEM register keeps its value.
- memWb_bubble  output  1  MEM/WB register loads a NOP.
- mem_error  output  1  sticky flag: memory timeout occurred.
- stall_cycles  output  32  stall-cycle count (optional feature).
- flush_count  output  32  flush count (optional feature).

Behaviour:
- Single clock clk. reset is asynchronous and active-high.
- State register: RUN, LU_STALL, MEM_WAIT. Also a 2-bit bubble counter, an 8-bit timeout counter and a 1-bit ret_lu (return-to-LU_STALL) flag.
- While reset is high or on the cycle after release:
  - state=RUN, counters=0, mem_error=0.
  - Outputs: pc_write=0, ifId_write=0, ifId_flush=1, idEx_bubble=1, idEx_hold=0, exMem_hold=0, memWb_bubble=1.
- Outputs are combinational from the current state and inputs. The state and counters update on the clk rising edge.
- Hazard definition: lu_hazard = idEx_mem_read and idEx_write_reg!=0 and (idEx_write_reg==decode_read_reg1 or idEx_write_reg==decode_read_reg2). Register 0 never causes a hazard.
- Priority within a cycle: memory wait > load-use > branch.
- RUN:
  - Default outputs: pc_write=1, ifId_write=1, all others 0.
  - If dmem_req and not dmem_ready: assert the freeze set, go to MEM_WAIT, timeout counter=1, ret_lu=0.
  - Freeze set: pc_write=0, ifId_write=0, idEx_hold=1, exMem_hold=1, memWb_bubble=1.
  - Else if lu_hazard: pc_write=0, ifId_write=0, idEx_bubble=1. If LOAD_USE_BUBBLES>1, go to LU_STALL with bubble counter=LOAD_USE_BUBBLES-1.
  - Else if branch_taken: ifId_flush=1 and pc_write=1 (PC takes the target).
  - branch_taken is ignored in any cycle where decode is stalled; decode re-evaluates the branch later.
- LU_STALL:
  - Outputs: pc_write=0, ifId_write=0, idEx_bubble=1. The bubble counter decrements each cycle; at counter==1, go to RUN.
  - If dmem_req and not dmem_ready: the freeze set overrides, bubble counter is held, ret_lu=1, go to MEM_WAIT.
- MEM_WAIT:
  - Freeze set asserted every cycle. The timeout counter increments, saturating.
  - On dmem_ready: the freeze set is still asserted that cycle. The next state is LU_STALL if ret_lu, else RUN.
  - If the timeout counter reaches MEM_TIMEOUT without dmem_ready: mem_error<=1 (sticky until reset) and the next state is RUN/LU_STALL as above. The pipeline resumes and the access is abandoned.
- Back-to-back loads: each hazard is detected independently in RUN. No bubbles are merged.
- Reset asserted mid-stall: immediate return to the reset outputs and state RUN. The stall is not resumed.

Optional Feature:
- Macro HAZARD_STALL_COUNTERS_EN.
- When defined:
  - stall_cycles increments on every cycle with pc_write==0 after reset release.
  - flush_count increments on every cycle with ifId_flush==1 in RUN.
  - Both are 32-bit wrapping counters cleared by reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load-use hazard: idEx_mem_read=1, idEx_write_reg=5, decode_read_reg2=5 (LOAD_USE_BUBBLES=1) -> one cycle with pc_write=0, ifId_write=0, idEx_bubble=1, then pc_write=1.
- Register 0: same stimulus with idEx_write_reg=0 and decode_read_reg1=0 -> no stall; pc_write=1 throughout.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 4 freeze cycles (exMem_hold=1, memWb_bubble=1), then RUN outputs.
- Memory wait inside a load-use stall: LOAD_USE_BUBBLES=3, dmem stall of 2 cycles in the second bubble -> 3 idEx_bubble cycles total with the freeze between them, then RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_error rises after 4 MEM_WAIT cycles, state returns to RUN, mem_error stays 1 until reset.
- Branch during stall, then after: branch_taken=1 with lu_hazard=1 -> no flush. Next cycle branch_taken=1, no hazard -> ifId_flush=1 and, with HAZARD_STALL_COUNTERS_EN defined, flush_count goes 0->1.
